inst_mem_reader: RTL and testbench
==================================

Name: inst_mem_reader

Overview:
- Memory-controller-side instruction read engine. It is the producer end of the mem_inst_ready / mem_inst / mem_inst_addr interface that the icache consumes.
- On a fetcher miss request it reads 2 or 4 bytes from the byte-wide synchronous RAM. The count depends on the RVC length bits of the first halfword.
- It assembles the result into a 32-bit word and presents it for exactly one accepted cycle.
- It shares the RAM port with the data path through a simple grant from the memory arbiter.

Parameters:
XLEN, 32, instruction and address width
RAM_LAT, 1, RAM read latency in cycles; fixed at 1, other values unsupported

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset (0 = reset)
rdy  input  1  global ready; 0 freezes all state
flush  input  1  pipeline flush, synchronous abort
stall  input  1  consumer stall; result must not be presented while 1
fet_mem_req  input  1  fetcher requests instruction at fet_pc
fet_pc  input  XLEN  request address, halfword aligned
arb_grant  input  1  arbiter grants RAM port for the next cycle onward
ram_din  input  8  RAM read data, valid RAM_LAT cycles after address
ram_a  output  XLEN  RAM byte address
ram_rd_en  output  1  RAM read strobe
reader_busy  output  1  state != IDLE (to arbiter)
mem_inst_ready  output  1  result valid (to icache and fetcher)
mem_inst  output  XLEN  assembled instruction; upper 16 bits are 0 for RVC
mem_inst_addr  output  XLEN  address of mem_inst

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, internal byte registers 0.
- rdy=0: every register holds, ram_rd_en=0, mem_inst_ready=0. Resume continues exactly where it stopped.
- States: IDLE, RD0, RD1, RD2, RD3, RD4, DONE. Each state lasts one cycle unless stated otherwise.
- IDLE: when fet_mem_req && arb_grant && !flush, latch addr={fet_pc[XLEN-1:1],1'b0} and go to RD0. Otherwise stay. A request without grant is not latched.
- RD0: ram_a=addr, ram_rd_en=1.
- RD1: ram_a=addr+1, ram_rd_en=1; capture ram_din as b0.
- RD2: capture b1.
  - If b0[1:0]!=2'b11 (RVC): ram_rd_en=0, next state DONE.
  - Else: ram_a=addr+2, ram_rd_en=1, next state RD3.
- RD3: ram_a=addr+3, ram_rd_en=1; capture b2.
- RD4: ram_rd_en=0; capture b3; next state DONE.
- DONE:
  - mem_inst={b3,b2,b1,b0} (b3,b2 forced 0 for RVC); mem_inst_addr=addr.
  - mem_inst_ready=1 only while !stall. While stall=1, stay in DONE with ready=0.
  - First cycle with !stall: ready=1 for that one cycle, then go to IDLE.
- Latency from request-latching edge to ready high (no stall): RVC 4 cycles, 32-bit 6 cycles.
- Address arithmetic is XLEN-bit modulo 2^XLEN; addr+3 wraps at 0xFFFFFFFF.
- fet_mem_req is ignored while busy; the fetcher holds it until ready.
- flush=1 at any posedge in any state:
  - Next state is IDLE; ram_rd_en=0 and mem_inst_ready=0 that cycle onward.
  - Flush in DONE suppresses the ready pulse.
  - Flush in IDLE blocks a simultaneous request.
- flush and stall both high: flush wins.
- Async reset mid-read aborts immediately. No ready pulse is issued for the aborted read.
- arb_grant only gates leaving IDLE. Once busy, the port is owned until return to IDLE (the arbiter watches reader_busy).
- ram_a and mem_inst_addr are 0 when not driven in the current state.

Test Plan:
- RVC read: RAM[0x100]=0x01, [0x101]=0x45; req fet_pc=0x100 with grant -> ram_a 0x100,0x101 on consecutive cycles; 4 cycles later ready=1 for 1 cycle, mem_inst=0x00004501, mem_inst_addr=0x100.
- 32-bit read: RAM[0x200..0x203]=0x93,0x00,0x10,0x00 -> ram_a 0x200..0x203, ready after 6 cycles, mem_inst=0x00100093.
- Stall hold: 32-bit read with stall=1 from RD3 for 3 cycles -> ready stays 0, mem_inst stable; ready=1 exactly on the first cycle after stall drops; IDLE next.
- Flush: assert flush in RD2, then in DONE on a second read -> no ready pulse either time; state IDLE, reader_busy=0 next cycle.
- Grant and reset: req without grant for 5 cycles -> no RAM access; grant -> read starts. Drive rst=0 mid-RD3 -> outputs 0 immediately, and no ready pulse after release.
- Wrap and rdy: req fet_pc=0xFFFFFFFE, 32-bit -> ram_a sequence 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1. Hold rdy=0 for 2 cycles in RD1 -> identical result, with latency extended by 2.

Source files
------------

// File: rtl/inst_mem_reader.sv
// Instruction read engine: fetches a 16-bit (RVC) or 32-bit instruction byte by
// byte from the shared synchronous RAM and hands it to the icache/fetcher.
module inst_mem_reader #(
   parameter int XLEN    = 32,
   parameter int RAM_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            flush,
   input  logic            stall,
   input  logic            fet_mem_req,
   input  logic [XLEN-1:0] fet_pc,
   input  logic            arb_grant,
   input  logic [7:0]      ram_din,
   output logic [XLEN-1:0] ram_a,
   output logic            ram_rd_en,
   output logic            reader_busy,
   output logic            mem_inst_ready,
   output logic [XLEN-1:0] mem_inst,
   output logic [XLEN-1:0] mem_inst_addr
);

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      RD3,
      RD4,
      DONE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [XLEN-1:0] addr;
   logic [7:0]      b0;
   logic [7:0]      b1;
   logic [7:0]      b2;
   logic [7:0]      b3;
   logic            rd_req;
   logic [1:0]      a_off;
   logic            latch_req;
   logic            cap0;
   logic            cap1;
   logic            cap2;
   logic            cap3;
   logic            is_rvc;
   logic            unused_pc_lsb;

   if (RAM_LAT != 1) begin : g_lat_unsupported
      $error("inst_mem_reader supports RAM_LAT == 1 only");
   end

   assign unused_pc_lsb = fet_pc[0];
   assign is_rvc        = (b0[1:0] != 2'b11);

   // Data for the address driven in a state arrives one cycle later, so each
   // capture strobe sits one state behind the read it belongs to.
   always_comb begin
      next_state = state;
      rd_req     = 1'b0;
      a_off      = 2'd0;
      latch_req  = 1'b0;
      cap0       = 1'b0;
      cap1       = 1'b0;
      cap2       = 1'b0;
      cap3       = 1'b0;
      case (state)
         IDLE: begin
            if (fet_mem_req && arb_grant) begin
               latch_req  = 1'b1;
               next_state = RD0;
            end
         end
         RD0: begin
            rd_req     = 1'b1;
            next_state = RD1;
         end
         RD1: begin
            rd_req     = 1'b1;
            a_off      = 2'd1;
            cap0       = 1'b1;
            next_state = RD2;
         end
         RD2: begin
            cap1 = 1'b1;
            if (is_rvc) begin
               next_state = DONE;
            end else begin
               rd_req     = 1'b1;
               a_off      = 2'd2;
               next_state = RD3;
            end
         end
         RD3: begin
            rd_req     = 1'b1;
            a_off      = 2'd3;
            cap2       = 1'b1;
            next_state = RD4;
         end
         RD4: begin
            cap3       = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            if (!stall) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
      if (flush) begin
         next_state = IDLE;
         latch_req  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         addr  <= '0;
         b0    <= '0;
         b1    <= '0;
         b2    <= '0;
         b3    <= '0;
      end else if (rdy) begin
         state <= next_state;
         if (latch_req) addr <= {fet_pc[XLEN-1:1], 1'b0};
         if (cap0) b0 <= ram_din;
         if (cap1) b1 <= ram_din;
         if (cap2) b2 <= ram_din;
         if (cap3) b3 <= ram_din;
      end
   end

   // Strobes are gated by rdy and flush so a frozen or aborted cycle never
   // touches the RAM or signals a result.
   assign ram_rd_en      = rd_req && rdy && !flush;
   assign ram_a          = ram_rd_en ? addr + XLEN'(a_off) : '0;
   assign reader_busy    = (state != IDLE);
   assign mem_inst_ready = (state == DONE) && rdy && !flush && !stall;
   assign mem_inst       = (state != DONE) ? '0 :
                           is_rvc ? XLEN'({b1, b0}) : XLEN'({b3, b2, b1, b0});
   assign mem_inst_addr  = (state == DONE) ? addr : '0;

endmodule

// File: tb/tb_inst_mem_reader.sv
// Self-checking bench for inst_mem_reader: a transaction-level model plus
// directed scenarios with hand-computed results, then randomized traffic.
module tb_inst_mem_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        flush = 1'b0;
   logic        stall = 1'b0;
   logic        fet_mem_req = 1'b0;
   logic [31:0] fet_pc = '0;
   logic        arb_grant = 1'b0;
   logic [7:0]  ram_din = '0;
   logic [31:0] ram_a;
   logic        ram_rd_en;
   logic        reader_busy;
   logic        mem_inst_ready;
   logic [31:0] mem_inst;
   logic [31:0] mem_inst_addr;

   inst_mem_reader #(.XLEN(32), .RAM_LAT(1)) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .flush(flush),
      .stall(stall),
      .fet_mem_req(fet_mem_req),
      .fet_pc(fet_pc),
      .arb_grant(arb_grant),
      .ram_din(ram_din),
      .ram_a(ram_a),
      .ram_rd_en(ram_rd_en),
      .reader_busy(reader_busy),
      .mem_inst_ready(mem_inst_ready),
      .mem_inst(mem_inst),
      .mem_inst_addr(mem_inst_addr)
   );

   always #5 clk = ~clk;

   // Byte RAM, aliased on the low 8 address bits; output holds when not read.
   logic [7:0] mem [0:255];
   always @(posedge clk) begin
      if (ram_rd_en) ram_din <= mem[ram_a[7:0]];
   end

   int          nChecks = 0;
   int          nPass = 0;
   logic [31:0] cyc = '0;
   logic [31:0] raQ [$];
   logic [31:0] rdyInstQ [$];
   logic [31:0] rdyAddrQ [$];
   logic [31:0] rdyCycQ [$];

   // Model: a transaction is a list of mLen byte reads at mAddr+step, one
   // quiet step, then the result step that waits out stall.
   bit          mBusy = 1'b0;
   int          mStep = 0;
   int          mLen = 2;
   logic [31:0] mAddr = '0;
   logic [31:0] mInst = '0;
   logic        eEn;
   logic        eRdy;
   logic        eDone;
   logic [31:0] eA;
   logic [31:0] tA;
   logic [7:0]  tB;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] qAt(input logic [31:0] q [$], input int i);
      return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
   endfunction

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (!rst) begin
         mBusy = 1'b0;
         mStep = 0;
      end
      eDone = mBusy && (mStep == mLen + 1);
      eEn   = rst && rdy && !flush && mBusy && (mStep < mLen);
      eA    = eEn ? mAddr + 32'(mStep) : 32'h0;
      eRdy  = rst && rdy && !flush && !stall && eDone;
      checkOutput("ram_rd_en", 32'(ram_rd_en), 32'(eEn));
      checkOutput("ram_a", ram_a, eA);
      checkOutput("reader_busy", 32'(reader_busy), 32'(mBusy));
      checkOutput("mem_inst_ready", 32'(mem_inst_ready), 32'(eRdy));
      checkOutput("mem_inst", mem_inst, eDone ? mInst : 32'h0);
      checkOutput("mem_inst_addr", mem_inst_addr, eDone ? mAddr : 32'h0);
      if (ram_rd_en) raQ.push_back(ram_a);
      if (mem_inst_ready) begin
         rdyInstQ.push_back(mem_inst);
         rdyAddrQ.push_back(mem_inst_addr);
         rdyCycQ.push_back(cyc);
      end
      if (rst && rdy) begin
         if (flush) begin
            mBusy = 1'b0;
         end else if (!mBusy) begin
            if (fet_mem_req && arb_grant) begin
               mBusy = 1'b1;
               mStep = 0;
               mAddr = {fet_pc[31:1], 1'b0};
               tB    = mem[mAddr[7:0]];
               mLen  = (tB[1:0] == 2'b11) ? 4 : 2;
               mInst = '0;
               for (int k = 0; k < mLen; k++) begin
                  tA = mAddr + 32'(k);
                  mInst[8*k +: 8] = mem[tA[7:0]];
               end
            end
         end else if (eDone) begin
            if (!stall) mBusy = 1'b0;
         end else begin
            mStep++;
         end
      end
   end

   task automatic applyStimulus(input logic req, input logic [31:0] pc, input logic gnt,
                                input logic st, input logic fl, input logic rd);
      fet_mem_req = req;
      fet_pc      = pc;
      arb_grant   = gnt;
      stall       = st;
      flush       = fl;
      rdy         = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic clearQueues();
      raQ.delete();
      rdyInstQ.delete();
      rdyAddrQ.delete();
      rdyCycQ.delete();
   endtask

   // Offsets are in cycles after the request cycle (offset 0); the fetcher
   // holds its request until the result appears or a flush is issued.
   task automatic doRead(input logic [31:0] pc, input int sFrom, input int sTo, input int flAt,
                         input int rFrom, input int rTo, output logic [31:0] reqCyc);
      logic req;
      clearQueues();
      reqCyc = '0;
      for (int i = 0; i < 20; i++) begin
         req = (i == 0) || (rdyCycQ.size() == 0 && (flAt < 0 || i < flAt));
         applyStimulus(req, pc, i == 0, (i >= sFrom) && (i <= sTo), i == flAt,
                       !((i >= rFrom) && (i <= rTo)));
         if (i == 0) reqCyc = cyc;
         if (rdyCycQ.size() != 0) break;
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic setBytes(input logic [7:0] a, input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3);
      mem[a]        = d0;
      mem[a + 8'd1] = d1;
      mem[a + 8'd2] = d2;
      mem[a + 8'd3] = d3;
   endtask

   logic [31:0] rc;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      #2 rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("reset_busy", 32'(reader_busy), 32'h0);
      checkOutput("reset_rd_en", 32'(ram_rd_en), 32'h0);
      checkOutput("reset_ready", 32'(mem_inst_ready), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("[TB] RVC read");
      setBytes(8'h00, 8'h01, 8'h45, 8'h00, 8'h00);
      doRead(32'h100, -1, -2, -1, -1, -2, rc);
      checkOutput("rvc_reads", raQ.size(), 2);
      checkOutput("rvc_a0", qAt(raQ, 0), 32'h100);
      checkOutput("rvc_a1", qAt(raQ, 1), 32'h101);
      checkOutput("rvc_pulses", rdyCycQ.size(), 1);
      checkOutput("rvc_latency", qAt(rdyCycQ, 0) - rc, 32'd4);
      checkOutput("rvc_inst", qAt(rdyInstQ, 0), 32'h0000_4501);
      checkOutput("rvc_addr", qAt(rdyAddrQ, 0), 32'h100);

      $display("[TB] 32-bit read");
      setBytes(8'h00, 8'h93, 8'h00, 8'h10, 8'h00);
      doRead(32'h200, -1, -2, -1, -1, -2, rc);
      checkOutput("w32_reads", raQ.size(), 4);
      checkOutput("w32_a3", qAt(raQ, 3), 32'h203);
      checkOutput("w32_latency", qAt(rdyCycQ, 0) - rc, 32'd6);
      checkOutput("w32_inst", qAt(rdyInstQ, 0), 32'h0010_0093);

      $display("[TB] stall hold");
      doRead(32'h200, 4, 6, -1, -1, -2, rc);
      checkOutput("stall_pulses", rdyCycQ.size(), 1);
      checkOutput("stall_latency", qAt(rdyCycQ, 0) - rc, 32'd7);
      checkOutput("stall_inst", qAt(rdyInstQ, 0), 32'h0010_0093);

      $display("[TB] flush");
      doRead(32'h200, -1, -2, 3, -1, -2, rc);
      checkOutput("flush_rd2_pulses", rdyCycQ.size(), 0);
      checkOutput("flush_rd2_busy", 32'(reader_busy), 32'h0);
      doRead(32'h200, -1, -2, 6, -1, -2, rc);
      checkOutput("flush_done_pulses", rdyCycQ.size(), 0);
      doRead(32'h200, 6, 9, 8, -1, -2, rc);
      checkOutput("flush_stall_pulses", rdyCycQ.size(), 0);

      $display("[TB] grant gating");
      setBytes(8'h00, 8'h01, 8'h45, 8'h00, 8'h00);
      clearQueues();
      repeat (5) applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("nogrant_reads", raQ.size(), 0);
      checkOutput("nogrant_busy", 32'(reader_busy), 32'h0);
      doRead(32'h100, -1, -2, -1, -1, -2, rc);
      checkOutput("grant_inst", qAt(rdyInstQ, 0), 32'h0000_4501);

      $display("[TB] reset mid-read");
      setBytes(8'h00, 8'h93, 8'h00, 8'h10, 8'h00);
      applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rd3_rd_en", 32'(ram_rd_en), 32'h1);
      checkOutput("rd3_ram_a", ram_a, 32'h203);
      #2 rst = 1'b0;
      #1;
      checkOutput("areset_rd_en", 32'(ram_rd_en), 32'h0);
      checkOutput("areset_ram_a", ram_a, 32'h0);
      checkOutput("areset_busy", 32'(reader_busy), 32'h0);
      @(posedge clk);
      #1;
      fet_mem_req = 1'b0;
      rst = 1'b1;
      clearQueues();
      repeat (10) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("areset_pulses", rdyCycQ.size(), 0);

      $display("[TB] address wrap with rdy hold");
      mem[8'hFE] = 8'h13;
      mem[8'hFF] = 8'h05;
      mem[8'h00] = 8'hA0;
      mem[8'h01] = 8'h00;
      doRead(32'hFFFF_FFFE, -1, -2, -1, 2, 3, rc);
      checkOutput("wrap_reads", raQ.size(), 4);
      checkOutput("wrap_a0", qAt(raQ, 0), 32'hFFFF_FFFE);
      checkOutput("wrap_a1", qAt(raQ, 1), 32'hFFFF_FFFF);
      checkOutput("wrap_a2", qAt(raQ, 2), 32'h0000_0000);
      checkOutput("wrap_a3", qAt(raQ, 3), 32'h0000_0001);
      checkOutput("wrap_latency", qAt(rdyCycQ, 0) - rc, 32'd8);
      checkOutput("wrap_inst", qAt(rdyInstQ, 0), 32'h00A0_0513);
      checkOutput("wrap_addr", qAt(rdyAddrQ, 0), 32'hFFFF_FFFE);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
      end
      for (int i = 0; i < 600; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 9) != 0);
      end
      repeat (10) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
